// File: rtl/cordic_pre_rotate.sv
// Quadrant pre-rotation front end for the CORDIC rotation pipeline.
// Two registered stages with valid/ready backpressure; fold the angle into +/-pi/2 and seed x/y.
module cordic_pre_rotate #(
  parameter int unsigned      WIDTH  = 32,
  parameter int unsigned      TAG_W  = 8,
  parameter logic [WIDTH-1:0] K_INIT = 32'h26DD3B6A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_angle,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] QUARTER = {2'b01, {(WIDTH-2){1'b0}}};
  localparam logic [WIDTH-1:0] K_NEG   = ZERO - K_INIT;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_angle_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] x_q, y_q, z_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] x_d, y_d, z_d;
  logic             adv1_s, adv2_s;

  // Stall chain: in_ready depends combinationally on out_ready so a full pipe still streams.
  assign adv2_s   = ~out_valid_q | out_ready;
  assign adv1_s   = ~s1_valid_q | adv2_s;
  assign in_ready = adv1_s;

  // Quadrant fold: rotate by +/-pi/2 so the residual angle stays within [-pi/2, +pi/2).
  always_comb begin
    x_d = K_INIT;
    y_d = ZERO;
    z_d = s1_angle_q;
    case (s1_angle_q[WIDTH-1 -: 2])
      2'b00, 2'b11: begin
        x_d = K_INIT;
        y_d = ZERO;
        z_d = s1_angle_q;
      end
      2'b01: begin
        x_d = ZERO;
        y_d = K_INIT;
        z_d = s1_angle_q - QUARTER;
      end
      2'b10: begin
        x_d = ZERO;
        y_d = K_NEG;
        z_d = s1_angle_q + QUARTER;
      end
      default: begin
        x_d = K_INIT;
        y_d = ZERO;
        z_d = s1_angle_q;
      end
    endcase
  end

  // Stage 1: capture the incoming angle and tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_angle_q <= ZERO;
      s1_tag_q   <= {TAG_W{1'b0}};
    end else if (adv1_s) begin
      s1_valid_q <= in_valid & adv1_s;
      s1_angle_q <= in_angle;
      s1_tag_q   <= in_tag;
    end else begin
      s1_valid_q <= s1_valid_q;
    end
  end

  // Stage 2: output registers, held stable while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      x_q         <= ZERO;
      y_q         <= ZERO;
      z_q         <= ZERO;
      tag_q       <= {TAG_W{1'b0}};
    end else if (adv2_s) begin
      out_valid_q <= s1_valid_q;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      tag_q       <= s1_tag_q;
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

  assign out_valid = out_valid_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;
  assign tag_out   = tag_q;

endmodule

// File: tb/tb_cordic_pre_rotate.sv
// Scoreboard bench for cordic_pre_rotate: input monitor pushes reference results,
// output monitor pops and compares; directed, backpressure and random throughput phases.
module tb_cordic_pre_rotate;
  localparam logic [31:0] K = 32'h26DD3B6A;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [7:0]  tag;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_angle = 32'h0;
  logic [7:0]  in_tag = 8'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] x_out, y_out, z_out;
  logic [7:0]  tag_out;

  cordic_pre_rotate dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 32'd0;
  exp_t        sbq[$];
  bit          tp_phase = 1'b0;
  int          tp_pops = 0;
  logic [31:0] last_pop = 32'd0;
  logic        stall_prev = 1'b0;
  logic [103:0] prev_out = 104'd0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: signed angle in [-2^31, 2^31); fold by a quarter turn when outside [-2^30, 2^30).
  function automatic exp_t model(input logic [31:0] a, input logic [7:0] t, input logic [31:0] c);
    exp_t   e;
    longint sa;
    longint q;
    longint zz;
    sa = longint'($signed(a));
    q  = longint'(1) << 30;
    if (sa >= q) begin
      e.x = 32'd0; e.y = K; zz = sa - q;
    end else if (sa < -q) begin
      e.x = 32'd0; e.y = 32'(-longint'(K)); zz = sa + q;
    end else begin
      e.x = K; e.y = 32'd0; zz = sa;
    end
    e.z   = 32'(zz);
    e.tag = t;
    e.cyc = c;
    return e;
  endfunction

  // Input monitor: every accepted sample gets its expected result queued.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) sbq.push_back(model(in_angle, in_tag, cyc));
  end

  // Output monitor: compare on each accepted output; check hold-while-stalled.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) chk("hold_stable", {x_out, y_out, z_out, tag_out}, prev_out);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got tag %0h expected no output", tag_out);
        end else begin
          e = sbq.pop_front();
          chk("xyz_tag", {x_out, y_out, z_out, tag_out}, {e.x, e.y, e.z, e.tag});
          if (tp_phase) begin
            chk("latency", cyc - e.cyc, 32'd2);
            if (tp_pops > 0) chk("consecutive", cyc - last_pop, 32'd1);
          end
        end
        if (tp_phase) begin
          tp_pops  <= tp_pops + 1;
          last_pop <= cyc;
        end
      end
      if (!tp_phase) tp_pops <= 0;
      stall_prev <= out_valid && !out_ready;
      prev_out   <= {x_out, y_out, z_out, tag_out};
    end
  end

  task automatic send(input logic [31:0] a, input logic [7:0] t);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_angle = a;
    in_tag   = t;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no in_ready expected accept of tag %0h", t);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    bit done_r;
    logic [31:0] sweep[4];
    logic [31:0] bnd[4];
    sweep = '{32'h20000000, 32'h60000000, 32'hA0000000, 32'hE0000000};
    bnd   = '{32'h40000000, 32'h80000000, 32'hC0000000, 32'h3FFFFFFF};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_data", {x_out, y_out, z_out, tag_out}, 0);
    rst = 1'b0;

    // Two samples in flight, then reset mid-stream.
    out_ready = 1'b0;
    send(32'h11111111, 8'hA1);
    send(32'h55555555, 8'hA2);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset_valid", out_valid, 0);
    chk("midreset_data", {x_out, y_out, z_out, tag_out}, 0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h00000000, 8'h5A);
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_first", {out_valid, x_out, y_out, z_out}, {1'b1, 32'h26DD3B6A, 32'h0, 32'h0});
    drain();

    for (int i = 0; i < 4; i++) send(sweep[i], 8'(i + 1));
    for (int i = 0; i < 4; i++) send(bnd[i], 8'(i + 5));
    drain();

    // Six samples with out_ready low for a five-cycle window.
    fork
      begin
        for (int i = 0; i < 6; i++) send($urandom, 8'(8'h10 + i));
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", {out_valid, in_ready}, {1'b1, 1'b0});
      end
    join
    drain();

    done_r = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send($urandom, 8'(8'h40 + i));
        done_r = 1'b1;
      end
      begin
        while (!done_r) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    tp_phase = 1'b1;
    for (int i = 0; i < 100; i++) send($urandom, 8'(i));
    drain();
    chk("tp_count", tp_pops, 100);
    tp_phase = 1'b0;

    chk("sb_empty_end", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_pre_rotate.md
Name: cordic_pre_rotate

Overview:
Input stage of the pipelined CORDIC rotation chain; sits directly upstream of the first shift-accumulate stage. It accepts a 32-bit binary angle and performs quadrant pre-rotation so the residual angle lies within ±π/2. It emits the initial x/y/z triple (x preloaded with the CORDIC gain reciprocal) plus a passthrough tag. It is a 2-deep valid/ready pipeline with full backpressure.

Parameters:
WIDTH, 32, datapath width of angle, x, y, z
TAG_W, 8, width of sideband tag carried alongside each sample
K_INIT, 32'h26DD3B6A, 1/K ≈ 0.6072529 in signed Q2.30, loaded as the initial vector magnitude

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  angle/tag valid
in_ready  output  1  stage can accept this cycle
in_angle  input  WIDTH  signed binary angle; 2^WIDTH = 2π, so 0x40000000 = +π/2, 0x80000000 = −π
in_tag  input  TAG_W  opaque sideband
out_valid  output  1  x/y/z/tag valid
out_ready  input  1  downstream accepts
x_out  output  WIDTH  initial x, signed Q2.30
y_out  output  WIDTH  initial y, signed Q2.30
z_out  output  WIDTH  residual angle, same binary-angle format, range [−2^30, +2^30)
tag_out  output  TAG_W  in_tag delayed with its sample

Behaviour:
- Reset (async, active-high):
  - s1_valid, out_valid ← 0.
  - All data registers (stage-1 angle/tag, x_out, y_out, z_out, tag_out) ← 0.
  - In-flight samples are discarded; no partial output after deassert.
- Pipeline registers:
  - Stage 1 captures in_angle and in_tag.
  - Stage 2 (output registers) holds the computed triple.
- Advance rules:
  - adv2 = ~out_valid | out_ready
  - adv1 = ~s1_valid | adv2
  - in_ready = adv1; this is combinational from out_ready, by design.
- Transfers:
  - Input transfer occurs on in_valid & in_ready.
  - When adv1: s1_valid ← in_valid & in_ready, and stage-1 data loads.
  - When adv2: out_valid ← s1_valid, and output data loads from stage 1.
  - When ~adv2: all outputs hold stable; out_valid stays 1 until accepted.
- Latency and throughput: 2 cycles from input transfer to out_valid when out_ready is held high; throughput is 1 sample/cycle.
- Quadrant map on angle bits [31:30] (computed between stage 1 and stage 2):
  - 00 or 11: x = K_INIT, y = 0, z = angle.
  - 01: x = 0, y = K_INIT, z = angle − 0x40000000.
  - 10: x = 0, y = −K_INIT (two's complement), z = angle + 0x40000000.
  - Arithmetic is modulo 2^WIDTH; no overflow is possible because the quadrant guarantees the result range.
- Boundary cases:
  - 0x40000000 → x = 0, y = K_INIT, z = 0.
  - 0x80000000 (−π) → x = 0, y = 0xD922C496, z = 0xC0000000.
  - 0xC0000000 (−π/2) → x = K_INIT, y = 0, z = 0xC0000000.
  - 0x3FFFFFFF → x = K_INIT, y = 0, z = 0x3FFFFFFF.
- Simultaneous accept and capture: when out_ready and in_valid are both high with both stages full, both stages advance in the same cycle and no bubble is inserted.
- Ordering: tag_out always corresponds to the angle that produced x/y/z. Samples are never reordered, duplicated, or dropped except by reset.

Test Plan:
- Reset: assert rst mid-stream with 2 samples in flight → out_valid = 0 and all outputs 0 immediately; after release, first new angle 0x00000000 → x = 0x26DD3B6A, y = 0, z = 0 two cycles later.
- Quadrant sweep (out_ready = 1), angles 0x20000000, 0x60000000, 0xA0000000, 0xE0000000 → z = 0x20000000, 0x20000000, 0xE0000000, 0xE0000000; (x,y) = (K,0), (0,K), (0,−K), (K,0). Tags 1..4 are preserved in order.
- Boundaries: angles 0x40000000, 0x80000000, 0xC0000000, 0x3FFFFFFF → values exactly as listed under Behaviour.
- Backpressure: stream 6 angles, out_ready low for cycles 3–7 → in_ready drops once both stages are full; outputs hold stable; all 6 samples emerge in order with no loss or duplication.
- Full throughput: in_valid and out_ready held high for 100 random angles → 100 outputs on consecutive cycles, each matching the reference model after 2-cycle latency.
